// File: rtl/ps2_cmd_decoder_if.sv
// Byte-stream input and game-command outputs of the PS/2 command decoder.
// The decoder sits on the slave side; whoever feeds bytes is the master.
interface ps2_cmd_decoder_if #(
    parameter int NUM_CMDS  = 4,
    parameter int CNT_WIDTH = 4
);
    logic [7:0]                    ps2_data;
    logic                          ps2_valid;
    logic [NUM_CMDS-1:0]           cmd_pulse;
    logic [NUM_CMDS-1:0]           cmd_held;
    logic [NUM_CMDS*CNT_WIDTH-1:0] press_count;
    logic                          unknown_key;

    modport master (
        output ps2_data, ps2_valid,
        input  cmd_pulse, cmd_held, press_count, unknown_key
    );

    modport slave (
        input  ps2_data, ps2_valid,
        output cmd_pulse, cmd_held, press_count, unknown_key
    );
endinterface

// File: rtl/ps2_cmd_decoder.sv
// PS/2 scan-code to game-command decoder: make/break/extended prefix parser,
// per-channel held level, press/auto-repeat pulses and wrapping press counters.
module ps2_cmd_decoder #(
    parameter int                    NUM_CMDS       = 4,
    parameter logic [NUM_CMDS*9-1:0] KEY_CODES      = {9'h172, 9'h174, 9'h16B, 9'h175},
    parameter logic [NUM_CMDS-1:0]   REPEAT_MASK    = 4'b1110,
    parameter int                    DAS_CYCLES     = 12_500_000,
    parameter int                    ARR_CYCLES     = 2_500_000,
    parameter int                    PREFIX_TIMEOUT = 2_500_000,
    parameter int                    CNT_WIDTH      = 4
) (
    input logic              CLOCK_50,
    input logic              reset,
    ps2_cmd_decoder_if.slave bus
);
    localparam int MAX_RPT = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
    localparam int TW      = $clog2(MAX_RPT + 1);
    localparam int PW      = $clog2(PREFIX_TIMEOUT + 1);

    localparam logic [TW-1:0] DAS_LAST = TW'(DAS_CYCLES - 1);
    localparam logic [TW-1:0] ARR_LAST = TW'(ARR_CYCLES - 1);
    localparam logic [PW-1:0] PTO_LAST = PW'(PREFIX_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } parse_state_t;

    parse_state_t state_q, state_d;
    logic [PW-1:0] pto_q;

    logic          ev_make;
    logic          ev_break;
    logic [8:0]    ev_code;
    logic [NUM_CMDS-1:0] hit;
    logic          found;

    logic [NUM_CMDS-1:0]  pulse_q;
    logic [NUM_CMDS-1:0]  held_q;
    logic [NUM_CMDS-1:0]  rpt_phase_q;
    logic [CNT_WIDTH-1:0] cnt_q   [NUM_CMDS];
    logic [TW-1:0]        timer_q [NUM_CMDS];
    logic                 unknown_q;

    // Parser state register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Cycles since the last received byte; only meaningful while a prefix is pending.
    always_ff @(posedge CLOCK_50) begin
        if (reset || bus.ps2_valid || state_q == S_IDLE) pto_q <= '0;
        else                                             pto_q <= pto_q + PW'(1);
    end

    // Next parser state and completed make/break events.
    always_comb begin
        state_d  = state_q;
        ev_make  = 1'b0;
        ev_break = 1'b0;
        ev_code  = '0;
        if (bus.ps2_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.ps2_data == 8'hE0)      state_d = S_EXT;
                    else if (bus.ps2_data == 8'hF0) state_d = S_BRK;
                    else begin
                        ev_make = 1'b1;
                        ev_code = {1'b0, bus.ps2_data};
                    end
                end
                S_EXT: begin
                    if (bus.ps2_data == 8'hF0)      state_d = S_EXT_BRK;
                    else if (bus.ps2_data == 8'hE0) state_d = S_EXT;
                    else begin
                        ev_make = 1'b1;
                        ev_code = {1'b1, bus.ps2_data};
                        state_d = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (bus.ps2_data != 8'hE0 && bus.ps2_data != 8'hF0) begin
                        ev_break = 1'b1;
                        ev_code  = {1'b0, bus.ps2_data};
                        state_d  = S_IDLE;
                    end
                end
                S_EXT_BRK: begin
                    if (bus.ps2_data != 8'hE0 && bus.ps2_data != 8'hF0) begin
                        ev_break = 1'b1;
                        ev_code  = {1'b1, bus.ps2_data};
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && pto_q == PTO_LAST) begin
            state_d = S_IDLE;
        end
    end

    // Priority match of the completed code against the channel table; lowest index wins.
    always_comb begin
        hit   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CMDS; i++) begin
            if (!found && ev_code == KEY_CODES[i*9 +: 9]) begin
                hit[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    // Per-channel held level, press/repeat pulses, counters and repeat timers.
    // A break takes precedence over a repeat due on the same edge, which is what
    // suppresses that repeat pulse; a make on a held key falls through to the
    // repeat branch so typematic bytes leave the timer alone.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pulse_q     <= '0;
            held_q      <= '0;
            rpt_phase_q <= '0;
            unknown_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_CMDS; i++) begin
                cnt_q[i]   <= '0;
                timer_q[i] <= '0;
            end
        end else begin
            pulse_q   <= '0;
            unknown_q <= ev_make && !found;
            for (int unsigned i = 0; i < NUM_CMDS; i++) begin
                if (ev_make && hit[i] && !held_q[i]) begin
                    held_q[i]      <= 1'b1;
                    pulse_q[i]     <= 1'b1;
                    cnt_q[i]       <= cnt_q[i] + CNT_WIDTH'(1);
                    timer_q[i]     <= '0;
                    rpt_phase_q[i] <= 1'b0;
                end else if (ev_break && hit[i] && held_q[i]) begin
                    held_q[i] <= 1'b0;
                end else if (held_q[i] && REPEAT_MASK[i] &&
                             timer_q[i] == (rpt_phase_q[i] ? ARR_LAST : DAS_LAST)) begin
                    pulse_q[i]     <= 1'b1;
                    timer_q[i]     <= '0;
                    rpt_phase_q[i] <= 1'b1;
                end else if (timer_q[i] != '1) begin
                    timer_q[i] <= timer_q[i] + TW'(1);
                end
            end
        end
    end

    // Pack channel state onto the interface.
    always_comb begin
        bus.press_count = '0;
        for (int unsigned i = 0; i < NUM_CMDS; i++) begin
            bus.press_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
        end
    end

    assign bus.cmd_pulse   = pulse_q;
    assign bus.cmd_held    = held_q;
    assign bus.unknown_key = unknown_q;

endmodule
